// File: rtl/dram_row_ctrl_pkg.sv
// Shared widths, FSM state and operation types for the row-buffer DRAM controller.
package dram_row_ctrl_pkg;

  localparam int ADDRESS_LEN        = 16;
  localparam int WIDTH              = 32;
  localparam int BURST_ACCESS_WIDTH = WIDTH;
  localparam int ROW_WIDTH          = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRECHARGE,
    ST_ACTIVATE,
    ST_CAS_WAIT,
    ST_READ_BURST,
    ST_WRITE_BURST,
    ST_WRITE_RECOVER,
    ST_COMPLETE,
    ST_REFRESH
  } dram_state_t;

  typedef enum logic {OP_RD, OP_WR} dram_op_t;

  function automatic int max5(int a, int b, int c, int d, int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/dram_timer.sv
// Loadable down-counter shared by all DRAM timing waits; done while the count is zero.
module dram_timer
  import dram_row_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) cnt_d = load_val;
    else if (cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/dram_row_ctrl.sv
// Open-row DRAM controller with backing store: ACT/CAS/PRE timing, write recovery and
// periodic refresh, serving full-row read/write bursts over a ready/valid/complete handshake.
module dram_row_ctrl
  import dram_row_ctrl_pkg::*;
#(
  parameter int ROWS        = 64,
  parameter int BURST_BEATS = 1,
  parameter int T_RP        = 3,
  parameter int T_RCD       = 3,
  parameter int T_CAS       = 2,
  parameter int T_WR        = 2,
  parameter int T_REFI      = 780,
  parameter int T_RFC       = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDRESS_LEN-1:0]        addr,
  input  logic                          read_en,
  input  logic                          write_en,
  input  logic [BURST_ACCESS_WIDTH-1:0] wdata,
  output logic                          dram_ready,
  output logic                          dram_complete,
  output logic [BURST_ACCESS_WIDTH-1:0] rdata,
  output logic                          valid
);

  localparam int RW    = $clog2(ROWS);
  localparam int DEPTH = ROWS * BURST_BEATS;
  localparam int IDXW  = $clog2(DEPTH);
  localparam int BW    = $clog2(BURST_BEATS + 1);
  localparam int TW    = $clog2(max5(T_RP, T_RCD, T_CAS, T_WR, T_RFC) + 1);
  localparam int RCW   = $clog2(T_REFI);

  dram_state_t state_q, state_d;
  dram_op_t    op_q, op_d;
  logic [RW-1:0]   row_q, row_d, open_row_q, open_row_d;
  logic            open_q, open_d, ref_path_q, ref_path_d, pending_q, pending_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [RCW-1:0]  ref_cnt_q, ref_cnt_d;
  logic [BURST_ACCESS_WIDTH-1:0] rdata_q, rdata_d;
  logic [BURST_ACCESS_WIDTH-1:0] store_q [DEPTH];

  logic            tmr_load, tmr_done, mem_we;
  logic [TW-1:0]   tmr_val;
  logic [IDXW-1:0] base, mem_waddr;
  logic            refresh_wrap, refresh_due, accept;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^addr[ADDRESS_LEN-1:RW];
  assign base           = IDXW'(row_q) * IDXW'(BURST_BEATS);
  assign refresh_wrap   = (ref_cnt_q == RCW'(T_REFI - 1));
  // A refresh that comes due in the same cycle as a request still wins.
  assign refresh_due    = pending_q | refresh_wrap;
  assign dram_ready     = (state_q == ST_IDLE) && !refresh_due;
  assign accept         = dram_ready && (read_en || write_en);
  assign dram_complete  = (state_q == ST_COMPLETE);
  assign valid          = (state_q == ST_READ_BURST) ||
                          ((state_q == ST_WRITE_BURST) && (beat_q != BW'(BURST_BEATS)));
  assign rdata          = rdata_q;

  dram_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    row_d      = row_q;
    open_d     = open_q;
    open_row_d = open_row_q;
    beat_d     = beat_q;
    ref_path_d = ref_path_q;
    rdata_d    = rdata_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    mem_we     = 1'b0;
    mem_waddr  = base + IDXW'(beat_q) - IDXW'(1);
    ref_cnt_d  = refresh_wrap ? '0 : ref_cnt_q + RCW'(1);
    pending_d  = pending_q | refresh_wrap;

    case (state_q)
      ST_IDLE: begin
        if (refresh_due) begin
          ref_path_d = 1'b1;
          tmr_load   = 1'b1;
          if (open_q) begin
            state_d = ST_PRECHARGE;
            tmr_val = TW'(T_RP - 1);
          end else begin
            state_d = ST_REFRESH;
            tmr_val = TW'(T_RFC - 1);
          end
        end else if (accept) begin
          op_d       = read_en ? OP_RD : OP_WR;
          row_d      = addr[RW-1:0];
          ref_path_d = 1'b0;
          tmr_load   = 1'b1;
          if (open_q && (open_row_q == addr[RW-1:0])) begin
            state_d = ST_CAS_WAIT;
            tmr_val = TW'(T_CAS - 1);
          end else if (open_q) begin
            state_d = ST_PRECHARGE;
            tmr_val = TW'(T_RP - 1);
          end else begin
            state_d = ST_ACTIVATE;
            tmr_val = TW'(T_RCD - 1);
          end
        end
      end
      ST_PRECHARGE: if (tmr_done) begin
        open_d   = 1'b0;
        tmr_load = 1'b1;
        if (ref_path_q) begin
          state_d = ST_REFRESH;
          tmr_val = TW'(T_RFC - 1);
        end else begin
          state_d = ST_ACTIVATE;
          tmr_val = TW'(T_RCD - 1);
        end
      end
      ST_ACTIVATE: if (tmr_done) begin
        open_d     = 1'b1;
        open_row_d = row_q;
        state_d    = ST_CAS_WAIT;
        tmr_load   = 1'b1;
        tmr_val    = TW'(T_CAS - 1);
      end
      ST_CAS_WAIT: if (tmr_done) begin
        beat_d = '0;
        if (op_q == OP_RD) begin
          state_d = ST_READ_BURST;
          rdata_d = store_q[base];
        end else begin
          state_d = ST_WRITE_BURST;
        end
      end
      ST_READ_BURST: begin
        if (beat_q == BW'(BURST_BEATS - 1)) begin
          state_d = ST_COMPLETE;
        end else begin
          beat_d  = beat_q + BW'(1);
          rdata_d = store_q[base + IDXW'(beat_q) + IDXW'(1)];
        end
      end
      // Each beat's data arrives the cycle after its valid, so the burst runs one extra cycle.
      ST_WRITE_BURST: begin
        mem_we = (beat_q != '0);
        if (beat_q == BW'(BURST_BEATS)) begin
          state_d  = ST_WRITE_RECOVER;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_WR - 1);
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      ST_WRITE_RECOVER: if (tmr_done) state_d = ST_COMPLETE;
      ST_COMPLETE:      state_d = ST_IDLE;
      ST_REFRESH: if (tmr_done) begin
        state_d    = ST_IDLE;
        open_d     = 1'b0;
        ref_path_d = 1'b0;
        pending_d  = refresh_wrap;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_RD;
      row_q      <= '0;
      open_q     <= 1'b0;
      open_row_q <= '0;
      beat_q     <= '0;
      ref_path_q <= 1'b0;
      ref_cnt_q  <= '0;
      pending_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      row_q      <= row_d;
      open_q     <= open_d;
      open_row_q <= open_row_d;
      beat_q     <= beat_d;
      ref_path_q <= ref_path_d;
      ref_cnt_q  <= ref_cnt_d;
      pending_q  <= pending_d;
      rdata_q    <= rdata_d;
    end
  end

  // The store survives reset; only a live write beat updates it.
  always_ff @(posedge clk) begin
    if (rst && mem_we) store_q[mem_waddr] <= wdata;
  end

endmodule
